// File: rtl/clock_monitor_pkg.sv
// Purpose : shared types and constants for the clock_monitor slice.
// Latency : n/a (package only).
// Backpressure: n/a (package only).
//
// Contents: FSM state enum, default configuration, derived tolerance
// bounds and helpers so overridden instances derive the same quantities.
package clock_monitor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACQ  = 2'd1,
        ST_LOCK = 2'd2
    } state_t;

    // Default configuration of the monitor.
    localparam int DEF_EXP_PERIOD = 8;
    localparam int DEF_TOL        = 1;
    localparam int DEF_LOCK_CNT   = 4;
    localparam int DEF_CNT_W      = 16;

    // Acceptance window and good-counter width for the default build.
    localparam int PER_MIN = DEF_EXP_PERIOD - DEF_TOL;
    localparam int PER_MAX = DEF_EXP_PERIOD + DEF_TOL;
    localparam int GOOD_W  = $clog2(DEF_LOCK_CNT + 1);

    // Same derivations for instances with overridden parameters.
    function automatic int per_min(input int exp_period, input int tol);
        return exp_period - tol;
    endfunction

    function automatic int per_max(input int exp_period, input int tol);
        return exp_period + tol;
    endfunction

    function automatic int good_w(input int lock_cnt);
        return $clog2(lock_cnt + 1);
    endfunction

endpackage

// File: rtl/clock_monitor_edge.sv
// Purpose : rising-edge detector for the monitored signal, optional 2-flop sync.
// Latency : o_edge is combinational from the sampled signal; +2 cycles when
//           CLOCK_MONITOR_SYNC_EN is defined. No backpressure (free-running).
//
// Ports: i_clk, i_rst_n (async, active-low), i_sig (monitored input),
//        o_edge (1-cycle pulse per rising edge).
// The delay flop resets to 0, so a signal already high out of reset is
// reported as an edge.
module clock_monitor_edge (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_sig,
    output logic o_edge
);

    logic sig_s;
    logic sig_d;

`ifdef CLOCK_MONITOR_SYNC_EN
    logic sig_m;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sig_m <= 1'b0;
            sig_s <= 1'b0;
        end else begin
            sig_m <= i_sig;
            sig_s <= sig_m;
        end
    end
`else
    // Source is synchronous to i_clk; feed it straight in.
    assign sig_s = i_sig;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sig_d <= 1'b0;
        end else begin
            sig_d <= sig_s;
        end
    end

    assign o_edge = sig_s & ~sig_d;

endmodule

// File: rtl/clock_monitor.sv
// Purpose : measures the period of i_sig in i_clk cycles, qualifies it (lock),
//           flags fast/slow/stalled inputs.
// Latency : all outputs registered, visible the cycle after the edge cycle.
//           No backpressure: reports are pulses that must be consumed on arrival.
//
// Ports: i_clk, i_rst_n (async, active-low), i_sig (monitored signal),
//        o_period / o_period_vld (measured period + 1-cycle strobe),
//        o_lock (level, high while qualified), o_err_fast / o_err_slow (pulses).
// Build option: CLOCK_MONITOR_SYNC_EN adds a 2-flop synchroniser on i_sig.
module clock_monitor
    import clock_monitor_pkg::*;
#(
    parameter int EXP_PERIOD = DEF_EXP_PERIOD,
    parameter int TOL        = DEF_TOL,
    parameter int LOCK_CNT   = DEF_LOCK_CNT,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_sig,
    output logic [CNT_W-1:0] o_period,
    output logic             o_period_vld,
    output logic             o_lock,
    output logic             o_err_fast,
    output logic             o_err_slow
);

    localparam int              GW      = good_w(LOCK_CNT);
    localparam logic [CNT_W-1:0] MIN_C  = CNT_W'(per_min(EXP_PERIOD, TOL));
    localparam logic [CNT_W-1:0] MAX_C  = CNT_W'(per_max(EXP_PERIOD, TOL));
    localparam logic [GW-1:0]    LOCK_C = GW'(LOCK_CNT);

    logic             edge_vld;
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [GW-1:0]    good;
    logic [CNT_W-1:0] period;
    logic [GW-1:0]    good_inc;
    logic             per_fast;
    logic             per_slow;

    clock_monitor_edge u_edge (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_sig   (i_sig),
        .o_edge  (edge_vld)
    );

    // cnt counts cycles since the previous edge, so the edge cycle itself adds one.
    assign period   = cnt + CNT_W'(1);
    assign good_inc = good + GW'(1);
    assign per_fast = (period < MIN_C);
    assign per_slow = (period > MAX_C);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            good         <= '0;
            o_period     <= '0;
            o_period_vld <= 1'b0;
            o_lock       <= 1'b0;
            o_err_fast   <= 1'b0;
            o_err_slow   <= 1'b0;
        end else begin
            o_period_vld <= 1'b0;
            o_err_fast   <= 1'b0;
            o_err_slow   <= 1'b0;

            case (state)
                ST_IDLE: begin
                    // First edge only sets the reference; there is no period yet.
                    cnt <= '0;
                    if (edge_vld) begin
                        state <= ST_ACQ;
                        good  <= '0;
                    end
                end

                ST_ACQ, ST_LOCK: begin
                    if (edge_vld) begin
                        // An edge coinciding with the timeout count lands here as a
                        // slow period, keeping the monitor in ACQ rather than IDLE.
                        cnt          <= '0;
                        o_period     <= period;
                        o_period_vld <= 1'b1;
                        if (per_fast || per_slow) begin
                            o_err_fast <= per_fast;
                            o_err_slow <= per_slow;
                            good       <= '0;
                            state      <= ST_ACQ;
                            o_lock     <= 1'b0;
                        end else if (state == ST_ACQ) begin
                            good <= good_inc;
                            if (good_inc == LOCK_C) begin
                                state  <= ST_LOCK;
                                o_lock <= 1'b1;
                            end
                        end
                        // Good period in LOCK: good is already saturated, nothing moves.
                    end else if (cnt == MAX_C) begin
                        // Input stalled: the next edge could only be too late.
                        cnt        <= '0;
                        good       <= '0;
                        o_err_slow <= 1'b1;
                        o_lock     <= 1'b0;
                        state      <= ST_IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                default: begin
                    cnt    <= '0;
                    good   <= '0;
                    o_lock <= 1'b0;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clock_monitor.sv
// Bench for clock_monitor with default parameters, i_sig synchronous to clk.
// A reference model tracks edge timestamps and the run of good periods,
// and every cycle all outputs are compared with it.
module tb_clock_monitor;

    localparam int EXP  = 8;
    localparam int TOL  = 1;
    localparam int LOCK = 4;
    localparam int CW   = 16;
    localparam int PMIN = EXP - TOL;
    localparam int PMAX = EXP + TOL;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          sig;
    logic [CW-1:0] o_period;
    logic          o_period_vld;
    logic          o_lock;
    logic          o_err_fast;
    logic          o_err_slow;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int  cyc;
    bit  m_prev;
    int  m_last;     // cycle of the previous edge, -1 when no reference
    int  m_run;      // consecutive good periods
    int  e_period;
    bit  e_vld, e_lock, e_fast, e_slow;

    clock_monitor #(
        .EXP_PERIOD (EXP),
        .TOL        (TOL),
        .LOCK_CNT   (LOCK),
        .CNT_W      (CW)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_sig        (sig),
        .o_period     (o_period),
        .o_period_vld (o_period_vld),
        .o_lock       (o_lock),
        .o_err_fast   (o_err_fast),
        .o_err_slow   (o_err_slow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        cyc      = 0;
        m_prev   = 1'b0;
        m_last   = -1;
        m_run    = 0;
        e_period = 0;
        e_vld    = 1'b0;
        e_lock   = 1'b0;
        e_fast   = 1'b0;
        e_slow   = 1'b0;
    endtask

    // Advance the model by one sampled value of sig.
    task automatic model_step(input bit s);
        bit rise;
        int per;
        rise   = s && !m_prev;
        m_prev = s;
        e_vld  = 1'b0;
        e_fast = 1'b0;
        e_slow = 1'b0;
        if (rise) begin
            if (m_last >= 0) begin
                per      = cyc - m_last;
                e_period = per;
                e_vld    = 1'b1;
                if (per < PMIN) begin
                    e_fast = 1'b1; m_run = 0; e_lock = 1'b0;
                end else if (per > PMAX) begin
                    e_slow = 1'b1; m_run = 0; e_lock = 1'b0;
                end else begin
                    m_run++;
                    if (m_run >= LOCK) e_lock = 1'b1;
                end
            end else begin
                m_run = 0;
            end
            m_last = cyc;
        end else if (m_last >= 0 && (cyc - m_last) == PMAX + 1) begin
            // No edge for PMAX+1 cycles: stalled input, drop the reference.
            e_slow = 1'b1;
            e_lock = 1'b0;
            m_last = -1;
            m_run  = 0;
        end
        cyc++;
    endtask

    task automatic cycle(input bit s);
        @(negedge clk);
        sig = s;
        @(posedge clk);
        model_step(s);
        #1;
        chk("period",     o_period,     e_period);
        chk("period_vld", o_period_vld, e_vld);
        chk("lock",       o_lock,       e_lock);
        chk("err_fast",   o_err_fast,   e_fast);
        chk("err_slow",   o_err_slow,   e_slow);
    endtask

    // One period of p cycles starting with a rising edge; random duty.
    task automatic send_period(input int p);
        int h;
        h = $urandom_range(p - 1, 1);
        for (int i = 0; i < p; i++) cycle(i < h);
    endtask

    task automatic send_fixed(input int p, input int h);
        for (int i = 0; i < p; i++) cycle(i < h);
    endtask

    task automatic hold_low(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_period"},   o_period,     0);
        chk({tag, "_vld"},      o_period_vld, 0);
        chk({tag, "_lock"},     o_lock,       0);
        chk({tag, "_err_fast"}, o_err_fast,   0);
        chk({tag, "_err_slow"}, o_err_slow,   0);
    endtask

    initial begin
        // Reset and scenario 1: 4 high / 4 low
        sig   = 1'b0;
        rst_n = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) send_fixed(8, 4);
        chk("scn1_locked", o_lock, 1);

        // Scenario 2: one fast period, then relock
        send_fixed(6, 3);
        for (int k = 0; k < 5; k++) send_fixed(8, 4);
        chk("scn2_relock", o_lock, 1);

        // Scenario 3: in-tolerance jitter keeps lock
        send_period(7);
        send_period(9);
        send_period(9);
        send_period(7);
        send_period(8);
        chk("scn3_lock", o_lock, 1);

        // Scenario 4: stall -> timeout -> IDLE, next edge reports nothing
        send_fixed(8, 4);
        hold_low(14);
        chk("scn4_unlock", o_lock, 0);
        for (int k = 0; k < 6; k++) send_period(8);

        // Scenario 5: period of 10 (edge coincides with timeout count)
        send_period(10);
        for (int k = 0; k < 6; k++) send_period(8);

        // Randomized periods with occasional stalls
        for (int k = 0; k < 60; k++) begin
            send_period($urandom_range(13, 4));
            if ($urandom_range(7, 0) == 0) hold_low($urandom_range(14, 1));
        end
        for (int k = 0; k < 5; k++) send_period(8);

        // Scenario 6: asynchronous reset mid-period
        send_fixed(8, 4);
        @(negedge clk);
        sig = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        model_reset();
        @(posedge clk);
        #1;
        check_all_zero("in_rst");
        @(negedge clk);
        sig   = 1'b0;
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) send_fixed(8, 4);
        chk("scn6_locked", o_lock, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/clock_monitor.md
# clock_monitor

Receive-side companion to the team's clock dividers: measures the period of a slow clock-like input `i_sig` in `i_clk` cycles. Reports each period, declares lock after `LOCK_CNT` consecutive in-tolerance periods, and flags fast, slow and stalled inputs. Used on divider outputs and external reference clocks to qualify them before downstream logic trusts them.

## Interface
- `EXP_PERIOD`, 8: expected period of `i_sig` in `i_clk` cycles. Must be ≥ 2.
- `TOL`, 1: allowed ± deviation in cycles. Must satisfy `TOL < EXP_PERIOD - 1`.
- `LOCK_CNT`, 4: consecutive good periods required to lock. Must be ≥ 1.
- `CNT_W`, 16: counter and `o_period` width. Must hold `EXP_PERIOD+TOL+1`.

Ports:
- `i_clk` in 1: the only clock.
- `i_rst_n` in 1: reset, asynchronous, active-low.
- `i_sig` in 1: monitored signal.
- `o_period` out CNT_W: last measured period; reset 0.
- `o_period_vld` out 1: 1-cycle pulse when `o_period` updates; reset 0.
- `o_lock` out 1: level, input qualified; reset 0.
- `o_err_fast` out 1: 1-cycle pulse, period < `EXP_PERIOD-TOL`; reset 0.
- `o_err_slow` out 1: 1-cycle pulse, period > `EXP_PERIOD+TOL` or timeout; reset 0.

## Operation
- Front end produces `edge`, a 1-cycle internal pulse on each rising edge of the (optionally synchronised) `i_sig`. The edge-detect delay flop resets to 0, so `i_sig` high out of reset counts as an edge.
- `cnt` clears on `edge`, otherwise increments. It is held at 0 in IDLE.
- At an edge in ACQ or LOCK, `period = cnt + 1`. A good period is `EXP_PERIOD-TOL ≤ period ≤ EXP_PERIOD+TOL`.
- `good` counts consecutive good periods and saturates at `LOCK_CNT`.
- States:
  - IDLE, the reset state: on `edge`, go to ACQ with `good=0`. No period is reported.
  - ACQ: on `edge`, report the period.
    - Good: `good+1`. When `good` reaches `LOCK_CNT`, go to LOCK.
    - Bad: pulse `o_err_fast` or `o_err_slow` as appropriate, set `good=0`, stay in ACQ. The edge becomes the new reference.
  - LOCK: on `edge`, report the period. A good period stays in LOCK. A bad period pulses the error, goes to ACQ with `good=0`, and deasserts `o_lock`.
  - ACQ or LOCK with no edge and `cnt == EXP_PERIOD+TOL` is a timeout: pulse `o_err_slow` and go to IDLE.
- An edge in the same cycle as the timeout condition takes priority. It is treated as a slow period: go to ACQ, not IDLE.
- `o_lock` is high exactly while in LOCK.
- Asserting reset at any point clears all state, counters and sync flops immediately. There is no pending report.

## Timing
- E is the cycle in which `edge` is high.
  - Without the sync macro: E is the first `i_clk` posedge sampling `i_sig=1`.
  - With the sync macro: E is 2 cycles later.
- All outputs are registered. `o_period`, `o_period_vld`, the errors and `o_lock` change at the posedge ending E, so they are visible in cycle E+1.
- `cnt` is 0 in E+1. The next edge in E+N gives `period = N`.
- With the defaults, a timeout fires in E+10 with no edge and is visible in E+11.
- Minimum `i_sig` high and low time is 1 cycle without sync and 2 cycles with sync. Shorter pulses may be missed.

## Configuration
- `CLOCK_MONITOR_SYNC_EN` defined: `i_sig` passes through a 2-flop synchroniser, reset to 0, before edge detection. This adds 2 cycles of latency. Use this setting for asynchronous inputs.
- `CLOCK_MONITOR_SYNC_EN` undefined: `i_sig` feeds edge detection directly. The source must be synchronous to `i_clk`, for example a divider on the same clock.

## Structure
- `clock_monitor_pkg` holds:
  - the state enum (IDLE, ACQ, LOCK);
  - derived constants `PER_MIN = EXP_PERIOD-TOL`, `PER_MAX = EXP_PERIOD+TOL`;
  - the `good` counter width `$clog2(LOCK_CNT+1)`.
- One sub-module, `clock_monitor_edge`: optional synchroniser, delay flop and rising-edge pulse. Top level keeps `cnt`, `good`, the FSM and the output registers.

## Test plan
All scenarios use the defaults (8/1/4), no sync macro, stimulus synchronous to `i_clk`.
- Reset, then `i_sig` 4 high / 4 low repeating → the first edge gives no `o_period_vld`. The next four edges each give `o_period=8` with a vld pulse. `o_lock` rises with the 4th report.
- Locked, then one period of 6 cycles → `o_err_fast` pulse and `o_period=6` with vld. `o_lock` falls in the same cycle. Lock returns after 4 further periods of 8.
- Locked, then periods of 7, 9, 9, 7 → no errors, `o_lock` stays high throughout.
- Locked, then `i_sig` held low → `o_err_slow` is visible 11 cycles after the last edge and `o_lock` falls. The FSM is in IDLE, and the next edge reports nothing.
- Locked, then next edge at period 10 → `o_err_slow` with `o_period=10`. The FSM is in ACQ, not IDLE.
- Locked, `i_rst_n` pulsed low mid-period → all outputs are 0 immediately. After release, the sequence matches scenario 1.
